prbs_checker: RTL and testbench
===============================

# prbs_checker

Receive-side PRBS checker that pairs with the PRBS generator: it self-synchronises to an incoming PN bit stream, declares lock, and counts bit errors and checked bits for loopback and BER measurement. It sits on the capture path after the ADC/comparator slicer, in the `dac_clk` domain. It is controlled by the same register set as the generator: PN select and enable.

## Interface
Parameters:
- `LOCK_THRESH`, 64: consecutive correct predictions required to declare lock.
- `LOSS_WINDOW`, 64: bit window for loss-of-lock evaluation while locked.
- `LOSS_THRESH`, 8: errors within one window that force loss of lock.

Ports:
- `dac_clk`  in  1  Block clock; one clock for the whole block.
- `reset`  in  1  Asynchronous, active-high reset.
- `prbs_check_enable`  in  1  0 = idle, state held.
- `prbs_pn_select_reg`  in  4  Polynomial select: 0 PN3 (x³+x²+1), 1 PN7 (x⁷+x⁶+1), 2 PN9 (x⁹+x⁵+1), 3 PN15 (x¹⁵+x¹⁴+1), 4 PN23 (x²³+x¹⁸+1), 5 PN31 (x³¹+x²⁸+1). Values 6–15 are treated as PN7.
- `prbs_bit_in`  in  1  Received bit.
- `prbs_bit_valid`  in  1  Qualifies `prbs_bit_in`; at most one bit per cycle.
- `prbs_clear_counters`  in  1  Synchronous clear of counters and sticky flag.
- `prbs_locked`  out  1  Checker is in LOCKED.
- `prbs_err_pulse`  out  1  One-cycle pulse per errored bit while locked.
- `prbs_err_count`  out  32  Errored bits since clear; saturating.
- `prbs_bit_count`  out  32  Bits checked while locked; saturating.
- `prbs_lost_lock_sticky`  out  1  Set on any LOCKED→SEED transition.

## Operation
- LFSR convention (identical to the generator):
  - Order N, state s[N-1:0].
  - new = s[a-1] ^ s[b-1], for polynomial taps a and b.
  - s <= {s[N-2:0], new}; the transmitted bit is `new`.
- All state advances happen only on cycles with `prbs_bit_valid`=1.
- States:
  - IDLE: entered on reset or `prbs_check_enable`=0. All non-counter state is cleared; counters and the sticky flag are held. On `prbs_check_enable`=1 → SEED.
  - SEED: shift received bits into s. After N bits:
    - If s is nonzero → VERIFY, with the consecutive-match counter = 0.
    - If s is zero → restart SEED.
  - VERIFY: compare `prbs_bit_in` against the predicted `new`, then shift the received bit in.
    - A mismatch, or s becoming all-zero → SEED.
    - Reaching LOCK_THRESH consecutive matches → LOCKED.
    - Nothing is counted in this state.
  - LOCKED: shift the predicted bit, not the received bit, so errors do not propagate.
    - Every valid bit increments `prbs_bit_count`.
    - Every mismatch increments `prbs_err_count` and pulses `prbs_err_pulse`.
    - A window counter counts valid bits modulo LOSS_WINDOW, and an error counter counts errors within the window. Both restart at each window boundary.
    - If the window error counter reaches LOSS_THRESH → SEED and set `prbs_lost_lock_sticky`.
- A change of `prbs_pn_select_reg` (compared against a registered copy) while not in IDLE → SEED in the next cycle. Counters are untouched.
- Counters saturate at 0xFFFF_FFFF and never wrap.
- `prbs_clear_counters` zeroes both counters and the sticky flag. If it coincides with an event, the clear wins and that cycle's increment is dropped. The FSM state is unaffected.

## Timing
- Reset values: `prbs_locked`=0, `prbs_err_pulse`=0, `prbs_err_count`=0, `prbs_bit_count`=0, `prbs_lost_lock_sticky`=0. The FSM resets to IDLE with s=0.
- All outputs are registered.
- `prbs_err_pulse` and the counter updates appear 1 cycle after the valid cycle carrying the errored or counted bit.
- `prbs_locked` rises 1 cycle after the valid cycle of the LOCK_THRESH-th match, so the minimum lock time from enable is N+LOCK_THRESH valid bits + 1 cycle.
- `prbs_locked` falls 1 cycle after the LOSS_THRESH-th window error, in the same cycle the sticky flag rises. It also falls 1 cycle after enable deasserts or the select changes.
- Reset asserted mid-operation immediately forces all reset values, asynchronously.
- Valid gaps of any length are tolerated; state holds across them.

## Structure
- Package `prbs_pkg`, shared with the generator, holds:
  - PN select constants.
  - Per-polynomial order and tap constants.
  - The maximum order (31).
  - The FSM state enum {IDLE, SEED, VERIFY, LOCKED}.
- Sub-module `prbs_lfsr_next`: combinational; takes the select and the 31-bit state and returns the next bit. The generator reuses it.

## Test plan
- PN7 error-free stream, enable=1 → `prbs_locked`=1 after 7+64 bits +1 cycle; after 1000 further bits `prbs_bit_count`=1000 and `prbs_err_count`=0.
- PN9 locked; invert 3 isolated bits spaced 100 apart → 3 `prbs_err_pulse`s, each 1 cycle after the flipped bit; `prbs_err_count`=3; lock is held.
- PN15 locked; invert 8 bits within one 64-bit window → lock drops and `prbs_lost_lock_sticky`=1; the clean stream relocks after 15+64 bits.
- All-zero input, enable=1 → never locks, stays in SEED/VERIFY; `prbs_bit_count`=0.
- Locked on PN3, switch the select to 1 (PN7) with PN7 data → one-cycle unlock, then relock after 7+64 bits; counters are retained.
- `prbs_clear_counters` asserted in the same cycle as an errored bit → both counters read 0 next cycle and no increment appears.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: polynomial constants, order/tap helpers and FSM states shared by the PRBS generator and checker
package prbs_pkg;
    localparam int PRBS_MAX_ORDER = 31;

    localparam logic [3:0] PN3  = 4'd0;
    localparam logic [3:0] PN7  = 4'd1;
    localparam logic [3:0] PN9  = 4'd2;
    localparam logic [3:0] PN15 = 4'd3;
    localparam logic [3:0] PN23 = 4'd4;
    localparam logic [3:0] PN31 = 4'd5;

    localparam logic [4:0] PN3_ORDER  = 5'd3;
    localparam logic [4:0] PN7_ORDER  = 5'd7;
    localparam logic [4:0] PN9_ORDER  = 5'd9;
    localparam logic [4:0] PN15_ORDER = 5'd15;
    localparam logic [4:0] PN23_ORDER = 5'd23;
    localparam logic [4:0] PN31_ORDER = 5'd31;

    localparam logic [4:0] PN3_TAP  = 5'd2;
    localparam logic [4:0] PN7_TAP  = 5'd6;
    localparam logic [4:0] PN9_TAP  = 5'd5;
    localparam logic [4:0] PN15_TAP = 5'd14;
    localparam logic [4:0] PN23_TAP = 5'd18;
    localparam logic [4:0] PN31_TAP = 5'd28;

    typedef enum logic [1:0] {IDLE, SEED, VERIFY, LOCKED} prbs_state_t;

    // Unassigned selects fall back to PN7
    function automatic logic [4:0] prbs_order(input logic [3:0] sel);
        return sel == PN3  ? PN3_ORDER  :
               sel == PN9  ? PN9_ORDER  :
               sel == PN15 ? PN15_ORDER :
               sel == PN23 ? PN23_ORDER :
               sel == PN31 ? PN31_ORDER : PN7_ORDER;
    endfunction

    function automatic logic [4:0] prbs_tap(input logic [3:0] sel);
        return sel == PN3  ? PN3_TAP  :
               sel == PN9  ? PN9_TAP  :
               sel == PN15 ? PN15_TAP :
               sel == PN23 ? PN23_TAP :
               sel == PN31 ? PN31_TAP : PN7_TAP;
    endfunction

    function automatic logic [PRBS_MAX_ORDER-1:0] prbs_mask(input logic [3:0] sel);
        return {PRBS_MAX_ORDER{1'b1}} >> (5'(PRBS_MAX_ORDER) - prbs_order(sel));
    endfunction
endpackage

// File: rtl/prbs_lfsr_next.sv
// prbs_lfsr_next: next LFSR output bit for the selected polynomial
module prbs_lfsr_next
    import prbs_pkg::*;
(
    input  logic [3:0]                sel,
    input  logic [PRBS_MAX_ORDER-1:0] state,
    output logic                      bit_next
);
    logic [4:0] a;
    logic [4:0] b;

    assign a = prbs_order(sel) - 5'd1;
    assign b = prbs_tap(sel) - 5'd1;
    assign bit_next = state[a] ^ state[b];
endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising PRBS receiver with lock tracking,
// loss-of-lock detection and saturating BER counters
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH = 64,
    parameter int LOSS_WINDOW = 64,
    parameter int LOSS_THRESH = 8
) (
    input  logic        dac_clk,
    input  logic        reset,
    input  logic        prbs_check_enable,
    input  logic [3:0]  prbs_pn_select_reg,
    input  logic        prbs_bit_in,
    input  logic        prbs_bit_valid,
    input  logic        prbs_clear_counters,
    output logic        prbs_locked,
    output logic        prbs_err_pulse,
    output logic [31:0] prbs_err_count,
    output logic [31:0] prbs_bit_count,
    output logic        prbs_lost_lock_sticky
);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = $clog2(LOSS_WINDOW + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    prbs_state_t state, state_n, cur;
    logic [PRBS_MAX_ORDER-1:0] s, s_n, s_rx, s_pred, mask;
    logic [4:0]    order, seed_cnt, seed_cnt_n;
    logic [MW-1:0] match_cnt, match_cnt_n;
    logic [WW-1:0] win_cnt, win_cnt_n;
    logic [EW-1:0] win_err, win_err_n, win_sum;
    logic [3:0]    sel_q;
    logic          pred, match, sel_chg, step, seed_done, win_end, bit_ev, err_ev, lost;

    prbs_lfsr_next u_next (
        .sel      (prbs_pn_select_reg),
        .state    (s),
        .bit_next (pred)
    );

    // IDLE with enable behaves as SEED so the first valid bit is already seeded
    assign cur       = state == IDLE ? SEED : state;
    assign order     = prbs_order(prbs_pn_select_reg);
    assign mask      = prbs_mask(prbs_pn_select_reg);
    assign s_rx      = {s[PRBS_MAX_ORDER-2:0], prbs_bit_in} & mask;
    assign s_pred    = {s[PRBS_MAX_ORDER-2:0], pred} & mask;
    assign match     = prbs_bit_in == pred;
    assign sel_chg   = state != IDLE && prbs_pn_select_reg != sel_q;
    assign step      = prbs_check_enable && !sel_chg && prbs_bit_valid;
    assign seed_done = seed_cnt == order - 5'd1;
    assign win_sum   = win_err + EW'(!match);
    assign win_end   = win_cnt == WW'(LOSS_WINDOW - 1);
    assign bit_ev    = step && state == LOCKED;
    assign err_ev    = bit_ev && !match;
    assign lost      = bit_ev && win_sum == EW'(LOSS_THRESH);

    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s         <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            sel_q     <= '0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            seed_cnt  <= seed_cnt_n;
            match_cnt <= match_cnt_n;
            win_cnt   <= win_cnt_n;
            win_err   <= win_err_n;
            sel_q     <= prbs_pn_select_reg;
        end
    end

    always_comb begin
        state_n = cur;
        if (!prbs_check_enable)
            state_n = IDLE;
        else if (sel_chg)
            state_n = SEED;
        else if (prbs_bit_valid) begin
            if (cur == SEED)
                state_n = seed_done && |s_rx ? VERIFY : SEED;
            else if (cur == VERIFY)
                state_n = !match || ~|s_rx ? SEED :
                          match_cnt == MW'(LOCK_THRESH - 1) ? LOCKED : VERIFY;
            else
                state_n = lost ? SEED : LOCKED;
        end
    end

    // Once locked, the prediction is shifted in so received errors cannot corrupt s
    always_comb begin
        s_n         = s;
        seed_cnt_n  = seed_cnt;
        match_cnt_n = match_cnt;
        win_cnt_n   = win_cnt;
        win_err_n   = win_err;
        if (step) begin
            s_n         = cur == LOCKED ? s_pred : s_rx;
            seed_cnt_n  = cur == SEED && !seed_done ? seed_cnt + 5'd1 : '0;
            match_cnt_n = cur == VERIFY ? match_cnt + MW'(1) : '0;
            win_cnt_n   = cur == LOCKED && !win_end ? win_cnt + WW'(1) : '0;
            win_err_n   = cur == LOCKED && !win_end ? win_sum : '0;
        end
        if (state_n == IDLE)
            s_n = '0;
        if (state_n != SEED || sel_chg)
            seed_cnt_n = '0;
        if (state_n != VERIFY)
            match_cnt_n = '0;
        if (state_n != LOCKED) begin
            win_cnt_n = '0;
            win_err_n = '0;
        end
    end

    always_ff @(posedge dac_clk or posedge reset) begin
        if (reset) begin
            prbs_locked           <= 1'b0;
            prbs_err_pulse        <= 1'b0;
            prbs_err_count        <= '0;
            prbs_bit_count        <= '0;
            prbs_lost_lock_sticky <= 1'b0;
        end else begin
            prbs_locked    <= state_n == LOCKED;
            prbs_err_pulse <= err_ev;
            if (prbs_clear_counters) begin
                prbs_err_count        <= '0;
                prbs_bit_count        <= '0;
                prbs_lost_lock_sticky <= 1'b0;
            end else begin
                if (bit_ev && ~&prbs_bit_count)
                    prbs_bit_count <= prbs_bit_count + 32'd1;
                if (err_ev && ~&prbs_err_count)
                    prbs_err_count <= prbs_err_count + 32'd1;
                if (state == LOCKED && state_n == SEED)
                    prbs_lost_lock_sticky <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prbs_checker.sv
// tb_prbs_checker: directed lock, error, loss-of-lock, select-change and clear scenarios
module tb_prbs_checker;
    logic        dac_clk = 1'b0;
    logic        reset = 1'b1;
    logic        prbs_check_enable = 1'b0;
    logic [3:0]  prbs_pn_select_reg = 4'd1;
    logic        prbs_bit_in = 1'b0;
    logic        prbs_bit_valid = 1'b0;
    logic        prbs_clear_counters = 1'b0;
    logic        prbs_locked, prbs_err_pulse, prbs_lost_lock_sticky;
    logic [31:0] prbs_err_count, prbs_bit_count;
    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [30:0] g;
    int          ga, gb;

    prbs_checker dut (
        .dac_clk               (dac_clk),
        .reset                 (reset),
        .prbs_check_enable     (prbs_check_enable),
        .prbs_pn_select_reg    (prbs_pn_select_reg),
        .prbs_bit_in           (prbs_bit_in),
        .prbs_bit_valid        (prbs_bit_valid),
        .prbs_clear_counters   (prbs_clear_counters),
        .prbs_locked           (prbs_locked),
        .prbs_err_pulse        (prbs_err_pulse),
        .prbs_err_count        (prbs_err_count),
        .prbs_bit_count        (prbs_bit_count),
        .prbs_lost_lock_sticky (prbs_lost_lock_sticky)
    );

    always #5 dac_clk = ~dac_clk;

    always @(negedge dac_clk)
        if (prbs_err_pulse)
            pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge dac_clk);
        #1;
    endtask

    task automatic send(input logic b);
        prbs_bit_in = b;
        prbs_bit_valid = 1'b1;
        tick();
        prbs_bit_valid = 1'b0;
    endtask

    task automatic reseed(input int a, input int b);
        ga = a;
        gb = b;
        g = '1;
    endtask

    task automatic gen(output logic b);
        b = g[ga-1] ^ g[gb-1];
        g = {g[29:0], b};
    endtask

    task automatic send_pn(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen(b);
            send(b);
        end
    endtask

    task automatic restart(input logic [3:0] sel, input int a, input int b);
        prbs_check_enable = 1'b0;
        tick();
        prbs_pn_select_reg = sel;
        prbs_clear_counters = 1'b1;
        tick();
        prbs_clear_counters = 1'b0;
        prbs_check_enable = 1'b1;
        reseed(a, b);
    endtask

    initial begin
        logic b;
        int p0;
        tick();
        tick();
        check("rst_locked", prbs_locked, 0);
        check("rst_pulse", prbs_err_pulse, 0);
        check("rst_err", prbs_err_count, 0);
        check("rst_bits", prbs_bit_count, 0);
        check("rst_sticky", prbs_lost_lock_sticky, 0);
        reset = 1'b0;
        tick();

        // PN7 clean stream with valid gaps after lock
        prbs_check_enable = 1'b1;
        reseed(7, 6);
        send_pn(70);
        check("pn7_prelock", prbs_locked, 0);
        send_pn(1);
        check("pn7_lock", prbs_locked, 1);
        for (int i = 0; i < 1000; i++) begin
            if (i % 13 == 0)
                tick();
            gen(b);
            send(b);
        end
        check("pn7_bits", prbs_bit_count, 1000);
        check("pn7_err", prbs_err_count, 0);
        check("pn7_held", prbs_locked, 1);
        prbs_check_enable = 1'b0;
        tick();
        check("dis_unlock", prbs_locked, 0);
        check("dis_bits_held", prbs_bit_count, 1000);

        // PN9 with three isolated errors
        restart(4'd2, 9, 5);
        check("clr_bits", prbs_bit_count, 0);
        send_pn(72);
        check("pn9_prelock", prbs_locked, 0);
        send_pn(1);
        check("pn9_lock", prbs_locked, 1);
        p0 = pulses;
        for (int i = 0; i < 300; i++) begin
            gen(b);
            send(b ^ (i == 50 || i == 150 || i == 250));
            if (i == 50 || i == 150 || i == 250)
                check("pn9_pulse", prbs_err_pulse, 1);
            if (i == 51)
                check("pn9_pulse_end", prbs_err_pulse, 0);
        end
        check("pn9_npulses", pulses - p0, 3);
        check("pn9_err", prbs_err_count, 3);
        check("pn9_bits", prbs_bit_count, 300);
        check("pn9_held", prbs_locked, 1);

        // PN15 burst of eight errors forces loss of lock
        restart(4'd3, 15, 14);
        send_pn(79);
        check("pn15_lock", prbs_locked, 1);
        for (int i = 0; i < 8; i++) begin
            gen(b);
            send(~b);
            if (i == 6)
                check("pn15_hold7", prbs_locked, 1);
        end
        check("pn15_lost", prbs_locked, 0);
        check("pn15_sticky", prbs_lost_lock_sticky, 1);
        check("pn15_err", prbs_err_count, 8);
        send_pn(78);
        check("pn15_prerelock", prbs_locked, 0);
        send_pn(1);
        check("pn15_relock", prbs_locked, 1);

        // all-zero input never locks
        restart(4'd1, 7, 6);
        for (int i = 0; i < 200; i++)
            send(1'b0);
        check("zero_unlocked", prbs_locked, 0);
        check("zero_bits", prbs_bit_count, 0);

        // PN3 lock, then switch select to PN7
        restart(4'd0, 3, 2);
        send_pn(67);
        check("pn3_lock", prbs_locked, 1);
        send_pn(20);
        check("pn3_bits", prbs_bit_count, 20);
        prbs_pn_select_reg = 4'd1;
        tick();
        check("sel_unlock", prbs_locked, 0);
        reseed(7, 6);
        send_pn(70);
        check("sel_prelock", prbs_locked, 0);
        send_pn(1);
        check("sel_relock", prbs_locked, 1);
        check("sel_bits_kept", prbs_bit_count, 20);
        check("sel_err_kept", prbs_err_count, 0);

        // clear coinciding with an errored bit wins
        prbs_clear_counters = 1'b1;
        gen(b);
        send(~b);
        prbs_clear_counters = 1'b0;
        check("clr_err", prbs_err_count, 0);
        check("clr_bits0", prbs_bit_count, 0);
        gen(b);
        send(b);
        check("clr_bits1", prbs_bit_count, 1);
        check("clr_err1", prbs_err_count, 0);

        // asynchronous reset mid-cycle
        #3 reset = 1'b1;
        #1;
        check("arst_bits", prbs_bit_count, 0);
        check("arst_locked", prbs_locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
